// File: rtl/wb_ddr_arbiter_rr.sv
// Round-robin Wishbone B3 arbiter sharing one DDR bridge port between NUM_MASTERS masters.
// The grant is held for the owner's whole cyc, and a watchdog aborts transfers that get no response.
module wb_ddr_arbiter_rr #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]          m_bte_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_rty_o,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [DATA_WIDTH/8-1:0]           s_sel_o,
    output logic [2:0]                        s_cti_o,
    output logic [1:0]                        s_bte_o,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    input  logic                              s_rty_i,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic [7:0]                        timeout_cnt_o
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WD_W      = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [7:0]             tcnt_q, tcnt_d;

    logic                   mux_cyc, mux_stb, mux_we;
    logic [ADDR_WIDTH-1:0]  mux_adr;
    logic [DATA_WIDTH-1:0]  mux_dat;
    logic [SEL_WIDTH-1:0]   mux_sel;
    logic [2:0]             mux_cti;
    logic [1:0]             mux_bte;
    logic [IDX_W-1:0]       pick_any, pick_hi, pick, next_ptr;
    logic                   found_hi, resp, in_grant, fire;

    // AND-OR mux on the registered one-hot grant; all zero while idle.
    always_comb begin
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        mux_we  = 1'b0;
        mux_adr = '0;
        mux_dat = '0;
        mux_sel = '0;
        mux_cti = '0;
        mux_bte = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                mux_cyc = mux_cyc | m_cyc_i[i];
                mux_stb = mux_stb | m_stb_i[i];
                mux_we  = mux_we  | m_we_i[i];
                mux_adr = mux_adr | m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                mux_dat = mux_dat | m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                mux_sel = mux_sel | m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
                mux_cti = mux_cti | m_cti_i[i*3 +: 3];
                mux_bte = mux_bte | m_bte_i[i*2 +: 2];
            end
        end
    end

    // Descending scan: the last hit is the lowest index, giving "first at or after ptr" with wrap.
    always_comb begin
        pick_any = '0;
        pick_hi  = '0;
        found_hi = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_cyc_i[i]) begin
                pick_any = IDX_W'(i);
                if (i >= int'(ptr_q)) begin
                    pick_hi  = IDX_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        pick = found_hi ? pick_hi : pick_any;
    end

    assign next_ptr = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
    assign resp     = s_ack_i | s_err_i | s_rty_i;
    assign in_grant = (state_q == ST_GRANT);
    // A response in the same cycle as the terminal count wins over the abort.
    assign fire     = in_grant & mux_cyc & mux_stb & ~resp &
                      (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (|m_cyc_i) begin
                    state_d = ST_GRANT;
                    owner_d = pick;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        grant_d[i] = (i == int'(pick));
                    end
                end
            end
            ST_GRANT: begin
                if (!mux_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    wd_d    = '0;
                end else if (fire) begin
                    state_d = ST_ABORT;
                    wd_d    = '0;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end else if (resp) begin
                    wd_d = '0;
                end else if (mux_stb) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_ABORT: begin
                if (!mux_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign s_cyc_o = in_grant & mux_cyc & ~fire;
    assign s_stb_o = in_grant & mux_stb & ~fire;
    assign s_we_o  = mux_we;
    assign s_adr_o = mux_adr;
    assign s_dat_o = mux_dat;
    assign s_sel_o = mux_sel;
    assign s_cti_o = mux_cti;
    assign s_bte_o = mux_bte;

    assign m_ack_o = in_grant ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
    assign m_err_o = in_grant ? (grant_q & {NUM_MASTERS{s_err_i | fire}}) : '0;
    assign m_rty_o = in_grant ? (grant_q & {NUM_MASTERS{s_rty_i}}) : '0;
    assign m_dat_o = s_dat_i;

    assign grant_o       = grant_q;
    assign timeout_cnt_o = tcnt_q;
endmodule

// File: tb/tb_wb_ddr_arbiter_rr.sv
// Bench for wb_ddr_arbiter_rr: a directed vector table plus hand-written multi-cycle sequences
// for bursts, watchdog abort, async reset and round-robin fairness.
module tb_wb_ddr_arbiter_rr;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    localparam logic [31:0] ADR0 = 32'h1000_0000;
    localparam logic [31:0] ADR1 = 32'h2000_0100;
    localparam logic [31:0] ADR2 = 32'h3000_0200;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
    logic [N*AW-1:0] m_adr_i;
    logic [N*DW-1:0] m_dat_i;
    logic [N*DW/8-1:0] m_sel_i;
    logic [N*3-1:0]  m_cti_i = '0;
    logic [N*2-1:0]  m_bte_i = '0;
    logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [DW/8-1:0] s_sel_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;
    logic            s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
    logic [DW-1:0]   s_dat_i = '0;
    logic [N-1:0]    grant_o;
    logic [7:0]      timeout_cnt_o;

    int checks = 0;
    int failures = 0;

    wb_ddr_arbiter_rr #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [2:0]  cyc;
        logic [2:0]  stb;
        logic        ack;
        logic        err;
        logic [31:0] sdat;
        logic [2:0]  e_grant;
        logic        e_cyc;
        logic        e_stb;
        logic [2:0]  e_ack;
        logic [2:0]  e_err;
        logic [31:0] e_adr;
    } vec_t;

    vec_t vecs[12];
    logic [2:0] burst_cti[4];
    logic [2:0] e_oh;

    initial begin
        m_adr_i = {ADR2, ADR1, ADR0};
        m_dat_i = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        m_sel_i = 12'hFFF;
        burst_cti[0] = 3'b010;
        burst_cti[1] = 3'b010;
        burst_cti[2] = 3'b010;
        burst_cti[3] = 3'b111;

        //          cyc     stb     ack   err   sdat          grant  cyc   stb   ack     err     adr
        vecs[0]  = '{3'b011, 3'b011, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 32'h0};
        vecs[1]  = '{3'b011, 3'b011, 1'b1, 1'b0, 32'h1111_1111, 3'b001, 1'b1, 1'b1, 3'b001, 3'b000, ADR0};
        vecs[2]  = '{3'b010, 3'b010, 1'b0, 1'b0, 32'h0,        3'b001, 1'b0, 1'b0, 3'b000, 3'b000, ADR0};
        vecs[3]  = '{3'b010, 3'b010, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 32'h0};
        vecs[4]  = '{3'b010, 3'b010, 1'b1, 1'b0, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b1, 3'b010, 3'b000, ADR1};
        vecs[5]  = '{3'b011, 3'b011, 1'b0, 1'b0, 32'h0,        3'b010, 1'b1, 1'b1, 3'b000, 3'b000, ADR1};
        vecs[6]  = '{3'b011, 3'b011, 1'b0, 1'b1, 32'h0,        3'b010, 1'b1, 1'b1, 3'b000, 3'b010, ADR1};
        vecs[7]  = '{3'b001, 3'b001, 1'b0, 1'b0, 32'h0,        3'b010, 1'b0, 1'b0, 3'b000, 3'b000, ADR1};
        vecs[8]  = '{3'b001, 3'b001, 1'b0, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 32'h0};
        vecs[9]  = '{3'b001, 3'b001, 1'b1, 1'b0, 32'h5555_AAAA, 3'b001, 1'b1, 1'b1, 3'b001, 3'b000, ADR0};
        vecs[10] = '{3'b000, 3'b000, 1'b0, 1'b0, 32'h0,        3'b001, 1'b0, 1'b0, 3'b000, 3'b000, ADR0};
        vecs[11] = '{3'b000, 3'b000, 1'b1, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 32'h0};

        // reset state
        #12;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_s_stb", 32'(s_stb_o), 32'h0);
        chk("rst_tcnt", 32'(timeout_cnt_o), 32'h0);
        chk("rst_m_ack", 32'(m_ack_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // arbitration, owner-only responses, IDLE gap, pointer advance
        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            m_cyc_i = vecs[v].cyc;
            m_stb_i = vecs[v].stb;
            s_ack_i = vecs[v].ack;
            s_err_i = vecs[v].err;
            s_dat_i = vecs[v].sdat;
            #1;
            chk($sformatf("v%0d_grant", v), 32'(grant_o), 32'(vecs[v].e_grant));
            chk($sformatf("v%0d_s_cyc", v), 32'(s_cyc_o), 32'(vecs[v].e_cyc));
            chk($sformatf("v%0d_s_stb", v), 32'(s_stb_o), 32'(vecs[v].e_stb));
            chk($sformatf("v%0d_m_ack", v), 32'(m_ack_o), 32'(vecs[v].e_ack));
            chk($sformatf("v%0d_m_err", v), 32'(m_err_o), 32'(vecs[v].e_err));
            chk($sformatf("v%0d_s_adr", v), s_adr_o, vecs[v].e_adr);
            if (vecs[v].ack) chk($sformatf("v%0d_m_dat", v), m_dat_o, vecs[v].sdat);
        end
        @(negedge clk);
        s_ack_i = 1'b0;
        s_err_i = 1'b0;

        // watchdog: M0 stb with no response, error pulse on 16th stb cycle
        m_cyc_i = 3'b001;
        m_stb_i = 3'b001;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            #1;
            if (k < TO) begin
                chk($sformatf("wd%0d_m_err", k), 32'(m_err_o), 32'h0);
                chk($sformatf("wd%0d_s_cyc", k), 32'(s_cyc_o), 32'h1);
            end else begin
                chk("wd_fire_m_err", 32'(m_err_o), 32'h1);
                chk("wd_fire_s_cyc", 32'(s_cyc_o), 32'h0);
                chk("wd_fire_s_stb", 32'(s_stb_o), 32'h0);
            end
        end
        @(negedge clk);
        #1;
        chk("abort_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("abort_m_err", 32'(m_err_o), 32'h0);
        chk("abort_grant", 32'(grant_o), 32'h1);
        chk("abort_tcnt", 32'(timeout_cnt_o), 32'h1);
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        @(negedge clk);
        #1;
        chk("abort_exit_grant", 32'(grant_o), 32'h0);

        // response on the terminal-count cycle wins
        m_cyc_i = 3'b001;
        m_stb_i = 3'b001;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            s_ack_i = (k == TO);
            #1;
        end
        chk("rw_m_err", 32'(m_err_o), 32'h0);
        chk("rw_m_ack", 32'(m_ack_o), 32'h1);
        chk("rw_s_cyc", 32'(s_cyc_o), 32'h1);
        @(negedge clk);
        s_ack_i = 1'b0;
        #1;
        chk("rw_after_s_cyc", 32'(s_cyc_o), 32'h1);
        chk("rw_after_tcnt", 32'(timeout_cnt_o), 32'h1);

        // async reset mid-transfer
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant_o), 32'h0);
        chk("arst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("arst_tcnt", 32'(timeout_cnt_o), 32'h0);
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;

        // 4-beat burst from M0 is not preempted by waiting M1
        @(negedge clk);
        m_cyc_i = 3'b011;
        m_stb_i = 3'b011;
        m_cti_i = {3'b000, 3'b000, 3'b010};
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            m_cti_i[2:0] = burst_cti[b];
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("burst%0d_grant", b), 32'(grant_o), 32'h1);
            chk($sformatf("burst%0d_cti", b), 32'(s_cti_o), 32'(burst_cti[b]));
            chk($sformatf("burst%0d_m_ack", b), 32'(m_ack_o), 32'h1);
        end
        @(negedge clk);
        s_ack_i = 1'b0;
        m_cyc_i = 3'b010;
        m_stb_i = 3'b010;
        #1;
        chk("burst_drop_grant", 32'(grant_o), 32'h1);
        chk("burst_drop_s_cyc", 32'(s_cyc_o), 32'h0);
        @(negedge clk);
        #1;
        chk("burst_gap_grant", 32'(grant_o), 32'h0);
        @(negedge clk);
        #1;
        chk("burst_m1_grant", 32'(grant_o), 32'h2);
        chk("burst_m1_adr", s_adr_o, ADR1);
        m_cyc_i = 3'b000;
        m_stb_i = 3'b000;
        m_cti_i = '0;

        // fairness: three masters always requesting, single-beat each
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_cyc_i = 3'b111;
        m_stb_i = 3'b111;
        for (int it = 0; it < 6; it++) begin
            int n;
            n = 0;
            e_oh = 3'b001 << (it % 3);
            while (grant_o == '0 && n < 8) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk($sformatf("rr%0d_grant", it), 32'(grant_o), 32'(e_oh));
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("rr%0d_m_ack", it), 32'(m_ack_o), 32'(e_oh));
            @(negedge clk);
            s_ack_i = 1'b0;
            m_cyc_i = ~e_oh;
            m_stb_i = ~e_oh;
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d_gap", it), 32'(grant_o), 32'h0);
            m_cyc_i = 3'b111;
            m_stb_i = 3'b111;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
